// File: rtl/phy_dly_seq.sv
`default_nettype none
// ============================================================================
//  Module   : phy_dly_seq
//  Purpose  : Multi-lane IODELAY programming sequencer. Keeps a shadow table
//             of 19 delay entries per byte lane and, on apply, streams the
//             selected entries onto the shared dly_data/dly_addr bus with a
//             per-lane ld_delay strobe, then issues a common set strobe.
//  Options  : PHY_DLY_SEQ_DIRTY_EN - issue only entries written since they
//             were last issued (per-entry dirty bits).
//  Revision : 1.0 - initial release
// ============================================================================
module phy_dly_seq #(
   parameter  int NUM_LANES = 2,
   parameter  int DLY_W     = 8,
   parameter  int SET_GAP   = 2,
   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                 clk_div,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [LANE_W+4:0]    wr_addr,
   input  logic [DLY_W-1:0]     wr_data,
   output logic                 wr_err,
   input  logic [LANE_W+4:0]    rd_addr,
   output logic [DLY_W-1:0]     rd_data,
   input  logic                 apply,
   input  logic [NUM_LANES-1:0] apply_mask,
   output logic                 busy,
   output logic                 done,
   output logic [DLY_W-1:0]     dly_data,
   output logic [4:0]           dly_addr,
   output logic [NUM_LANES-1:0] ld_delay,
   output logic [NUM_LANES-1:0] set
);

   localparam int c_ENT   = 19;
   localparam int c_TOT   = NUM_LANES * c_ENT;
   localparam int c_IDX_W = (c_TOT > 1) ? $clog2(c_TOT) : 1;
   localparam int c_GAP_W = $clog2(SET_GAP + 1);
   localparam logic [c_TOT-1:0] c_ONE = c_TOT'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_GAP  = 3'd2,
      S_SET  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Entries 0..9 are odelay taps, 16..24 idelay taps; packed into slots 0..18.
   function automatic logic f_ent_ok(input logic [4:0] e);
      return (e <= 5'd9) || ((e >= 5'd16) && (e <= 5'd24));
   endfunction

   function automatic logic [4:0] f_ent_slot(input logic [4:0] e);
      return (e <= 5'd9) ? e : (e - 5'd6);
   endfunction

   state_t                 r_state, w_state_nxt;
   logic [DLY_W-1:0]       r_shadow [c_TOT];
   logic [c_TOT-1:0]       r_todo, w_todo_nxt, w_todo_init, w_mask_exp, w_sel;
   logic [c_GAP_W-1:0]     r_gap, w_gap_nxt;
   logic [NUM_LANES-1:0]   r_mask, w_mask_nxt;
   logic [DLY_W-1:0]       r_dly_data, w_data_nxt, w_iss_data, r_rd_data;
   logic [4:0]             r_dly_addr, w_addr_nxt, w_iss_addr;
   logic [NUM_LANES-1:0]   r_ld, w_ld_nxt, w_iss_ld, r_set, w_set_nxt;
   logic                   r_done, w_done_nxt, r_busy, w_busy_nxt, r_wr_err;
   logic                   w_last;
   logic [LANE_W-1:0]      w_wr_lane, w_rd_lane;
   logic                   w_wr_ok, w_rd_ok, w_wr_acc;
   logic [c_IDX_W-1:0]     w_wr_idx, w_rd_idx;

   assign w_wr_lane = wr_addr[LANE_W+4:5];
   assign w_rd_lane = rd_addr[LANE_W+4:5];
   assign w_wr_ok   = f_ent_ok(wr_addr[4:0]) && (int'(w_wr_lane) < NUM_LANES);
   assign w_rd_ok   = f_ent_ok(rd_addr[4:0]) && (int'(w_rd_lane) < NUM_LANES);
   assign w_wr_idx  = c_IDX_W'(int'(w_wr_lane) * c_ENT + int'(f_ent_slot(wr_addr[4:0])));
   assign w_rd_idx  = c_IDX_W'(int'(w_rd_lane) * c_ENT + int'(f_ent_slot(rd_addr[4:0])));
   assign w_wr_acc  = wr_en && (r_state == S_IDLE) && w_wr_ok;

   // Pending entries are kept as a lane-major bit vector; the lowest set bit
   // is the next entry to issue, so clearing it walks the required order.
   assign w_sel  = r_todo & (~r_todo + c_ONE);
   assign w_last = ((r_todo & (r_todo - c_ONE)) == '0);

   // Expand the lane mask to one bit per shadow slot.
   always_comb begin
      w_mask_exp = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         w_mask_exp[l*c_ENT +: c_ENT] = {c_ENT{apply_mask[l]}};
      end
   end

`ifdef PHY_DLY_SEQ_DIRTY_EN
   logic [c_TOT-1:0] r_dirty, w_wr_vec, w_issue_vec;
   assign w_wr_vec    = w_wr_acc ? (c_ONE << w_wr_idx) : '0;
   assign w_issue_vec = (r_state == S_LOAD) ? w_sel : '0;
   // A same-cycle write is already dirty when the sequence is launched.
   assign w_todo_init = w_mask_exp & (r_dirty | w_wr_vec);

   // Dirty bits: set by accepted writes, cleared as each entry is issued.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         r_dirty <= '0;
      end else begin
         r_dirty <= (r_dirty | w_wr_vec) & ~w_issue_vec;
      end
   end
`else
   assign w_todo_init = w_mask_exp;
`endif

   // Decode the selected slot into its value, lane strobe and entry address.
   always_comb begin
      w_iss_data = '0;
      w_iss_addr = '0;
      w_iss_ld   = '0;
      for (int i = 0; i < c_TOT; i++) begin
         if (w_sel[i]) begin
            w_iss_data         = r_shadow[i];
            w_iss_ld[i / c_ENT] = 1'b1;
            w_iss_addr         = ((i % c_ENT) < 10) ? 5'(i % c_ENT) : 5'((i % c_ENT) + 6);
         end
      end
   end

   // Shadow table: written only while idle, cleared by reset.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_TOT; i++) begin
            r_shadow[i] <= '0;
         end
      end else if (w_wr_acc) begin
         r_shadow[w_wr_idx] <= wr_data;
      end
   end

   // Registered readback; invalid addresses read zero.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_ok ? r_shadow[w_rd_idx] : '0;
      end
   end

   // Next state and next registered outputs; bus values hold unless issuing.
   always_comb begin
      w_state_nxt = r_state;
      w_todo_nxt  = r_todo;
      w_gap_nxt   = r_gap;
      w_mask_nxt  = r_mask;
      w_data_nxt  = r_dly_data;
      w_addr_nxt  = r_dly_addr;
      w_ld_nxt    = '0;
      w_set_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_busy_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (apply) begin
               w_mask_nxt = apply_mask;
               if (apply_mask != '0) begin
                  w_state_nxt = S_LOAD;
                  w_todo_nxt  = w_todo_init;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_LOAD: begin
            w_busy_nxt = 1'b1;
            if (r_todo != '0) begin
               w_data_nxt = w_iss_data;
               w_addr_nxt = w_iss_addr;
               w_ld_nxt   = w_iss_ld;
               w_todo_nxt = r_todo & ~w_sel;
               if (w_last) begin
                  w_state_nxt = S_GAP;
                  w_gap_nxt   = '0;
               end
            end else if (SET_GAP == 1) begin
               // Nothing to load: this cycle already serves as the gap.
               w_state_nxt = S_SET;
            end else begin
               w_state_nxt = S_GAP;
               w_gap_nxt   = c_GAP_W'(1);
            end
         end
         S_GAP: begin
            w_busy_nxt = 1'b1;
            if (r_gap == c_GAP_W'(SET_GAP - 1)) begin
               w_state_nxt = S_SET;
            end else begin
               w_gap_nxt = r_gap + c_GAP_W'(1);
            end
         end
         S_SET: begin
            w_busy_nxt  = 1'b1;
            w_set_nxt   = r_mask;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any sequence immediately.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_todo     <= '0;
         r_gap      <= '0;
         r_mask     <= '0;
         r_dly_data <= '0;
         r_dly_addr <= '0;
         r_ld       <= '0;
         r_set      <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_todo     <= w_todo_nxt;
         r_gap      <= w_gap_nxt;
         r_mask     <= w_mask_nxt;
         r_dly_data <= w_data_nxt;
         r_dly_addr <= w_addr_nxt;
         r_ld       <= w_ld_nxt;
         r_set      <= w_set_nxt;
         r_done     <= w_done_nxt;
         r_busy     <= w_busy_nxt;
         r_wr_err   <= wr_en && !w_wr_acc;
      end
   end

   assign wr_err   = r_wr_err;
   assign rd_data  = r_rd_data;
   assign busy     = r_busy;
   assign done     = r_done;
   assign dly_data = r_dly_data;
   assign dly_addr = r_dly_addr;
   assign ld_delay = r_ld;
   assign set      = r_set;

endmodule
`default_nettype wire

// File: tb/tb_phy_dly_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phy_dly_seq
//  Purpose  : Self-checking bench for phy_dly_seq. A sequence-level model
//             turns each accepted apply into a per-cycle schedule of expected
//             bus activity; a negedge process compares every output to it.
//             Build with PHY_DLY_SEQ_DIRTY_EN to exercise the dirty option.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phy_dly_seq;

   localparam int NUM_LANES = 2;
   localparam int DLY_W     = 8;
   localparam int SET_GAP   = 2;
   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int AW        = LANE_W + 5;
`ifdef PHY_DLY_SEQ_DIRTY_EN
   localparam bit DIRTY = 1'b1;
`else
   localparam bit DIRTY = 1'b0;
`endif

   logic                 clk_div = 1'b0;
   logic                 rst;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [DLY_W-1:0]     wr_data;
   logic                 wr_err;
   logic [AW-1:0]        rd_addr;
   logic [DLY_W-1:0]     rd_data;
   logic                 apply;
   logic [NUM_LANES-1:0] apply_mask;
   logic                 busy;
   logic                 done;
   logic [DLY_W-1:0]     dly_data;
   logic [4:0]           dly_addr;
   logic [NUM_LANES-1:0] ld_delay;
   logic [NUM_LANES-1:0] set;

   phy_dly_seq #(.NUM_LANES(NUM_LANES), .DLY_W(DLY_W), .SET_GAP(SET_GAP)) u_dut (
      .clk_div(clk_div), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .apply(apply), .apply_mask(apply_mask), .busy(busy), .done(done),
      .dly_data(dly_data), .dly_addr(dly_addr), .ld_delay(ld_delay), .set(set)
   );

   always #5 clk_div = ~clk_div;

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [NUM_LANES-1:0] ld;
      logic [DLY_W-1:0]     data;
      logic [4:0]           addr;
      logic [NUM_LANES-1:0] set;
      logic                 done;
      logic                 busy;
   } rec_t;

   logic [DLY_W-1:0]     m_shadow [NUM_LANES][32];
   bit                   m_dirty  [NUM_LANES][32];
   rec_t                 sched[$];
   longint               edge_n, free_edge;
   logic [NUM_LANES-1:0] exp_ld, exp_set;
   logic [DLY_W-1:0]     exp_data, exp_rd;
   logic [4:0]           exp_addr;
   logic                 exp_done, exp_busy, exp_wr_err;
   bit                   chk_en;
   int                   vectors, miscompares;

   function automatic bit entry_ok(input int e);
      return (e <= 9) || ((e >= 16) && (e <= 24));
   endfunction

   function automatic rec_t blank_rec();
      rec_t r;
      r.ld = '0; r.data = '0; r.addr = '0; r.set = '0; r.done = 1'b0; r.busy = 1'b0;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int l = 0; l < NUM_LANES; l++)
         for (int e = 0; e < 32; e++) begin
            m_shadow[l][e] = '0;
            m_dirty[l][e]  = 1'b0;
         end
      sched.delete();
      free_edge  = 0;
      exp_ld = '0; exp_set = '0; exp_data = '0; exp_rd = '0; exp_addr = '0;
      exp_done = 1'b0; exp_busy = 1'b0; exp_wr_err = 1'b0;
   endtask

   // Apply the rules to the inputs sampled at this edge.
   task automatic model_edge();
      rec_t r;
      int   wl, we, rl, re, n;
      edge_n++;
      if (!rst) begin
         rl = int'(rd_addr[AW-1:5]);
         re = int'(rd_addr[4:0]);
         exp_rd = (rl < NUM_LANES && entry_ok(re)) ? m_shadow[rl][re] : '0;
         wl = int'(wr_addr[AW-1:5]);
         we = int'(wr_addr[4:0]);
         exp_wr_err = 1'b0;
         if (wr_en) begin
            if (edge_n >= free_edge && wl < NUM_LANES && entry_ok(we)) begin
               m_shadow[wl][we] = wr_data;
               m_dirty[wl][we]  = 1'b1;
            end else begin
               exp_wr_err = 1'b1;
            end
         end
         r = (sched.size() > 0) ? sched.pop_front() : blank_rec();
         exp_ld = r.ld; exp_set = r.set; exp_done = r.done; exp_busy = r.busy;
         if (r.ld != '0) begin
            exp_data = r.data;
            exp_addr = r.addr;
         end
         if (apply && edge_n >= free_edge) begin
            if (apply_mask == '0) begin
               r = blank_rec(); r.done = 1'b1; sched.push_back(r);
               free_edge = edge_n + 2;
            end else begin
               n = 0;
               for (int l = 0; l < NUM_LANES; l++) begin
                  if (apply_mask[l]) begin
                     for (int e = 0; e < 32; e++) begin
                        if (entry_ok(e) && (!DIRTY || m_dirty[l][e])) begin
                           r = blank_rec();
                           r.ld = NUM_LANES'(1) << l; r.data = m_shadow[l][e];
                           r.addr = 5'(e); r.busy = 1'b1;
                           sched.push_back(r);
                           m_dirty[l][e] = 1'b0;
                           n++;
                        end
                     end
                  end
               end
               for (int g = 0; g < SET_GAP; g++) begin
                  r = blank_rec(); r.busy = 1'b1; sched.push_back(r);
               end
               r = blank_rec(); r.set = apply_mask; r.busy = 1'b1; sched.push_back(r);
               r = blank_rec(); r.done = 1'b1; sched.push_back(r);
               free_edge = edge_n + n + SET_GAP + 3;
            end
         end
      end
   endtask

   // Compare every output against the model every cycle.
   always @(negedge clk_div) begin
      if (chk_en) begin
         check("ld_delay", 32'(ld_delay), 32'(exp_ld));
         check("set",      32'(set),      32'(exp_set));
         check("done",     32'(done),     32'(exp_done));
         check("busy",     32'(busy),     32'(exp_busy));
         check("dly_data", 32'(dly_data), 32'(exp_data));
         check("dly_addr", 32'(dly_addr), 32'(exp_addr));
         check("wr_err",   32'(wr_err),   32'(exp_wr_err));
         check("rd_data",  32'(rd_data),  32'(exp_rd));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk_div);
      #1;
      model_edge();
   endtask

   task automatic wr(input int l, input int e, input logic [DLY_W-1:0] d);
      wr_en = 1'b1; wr_addr = AW'(l * 32 + e); wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input int l, input int e, input logic [DLY_W-1:0] x);
      rd_addr = AW'(l * 32 + e);
      tick();
      check(nm, 32'(rd_data), 32'(x));
   endtask

   task automatic fill();
      for (int l = 0; l < NUM_LANES; l++)
         for (int e = 0; e < 32; e++)
            if (entry_ok(e)) wr(l, e, DLY_W'((l * 32 + e) ^ 'h3C));
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_ld"},   32'(ld_delay), 32'd0);
      check({nm, "_set"},  32'(set),      32'd0);
      check({nm, "_busy"}, 32'(busy),     32'd0);
      check({nm, "_done"}, 32'(done),     32'd0);
      check({nm, "_data"}, 32'(dly_data), 32'd0);
      check({nm, "_addr"}, 32'(dly_addr), 32'd0);
      check({nm, "_rd"},   32'(rd_data),  32'd0);
      check({nm, "_err"},  32'(wr_err),   32'd0);
   endtask

   initial begin
      vectors = 0; miscompares = 0; chk_en = 1'b0; edge_n = 0;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      apply = 1'b0; apply_mask = '0;
      model_reset();
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      chk_en = 1'b1;

      // write / readback
      wr(1, 17, 8'h5A);
      check("t1_wr_ok", 32'(wr_err), 32'd0);
      rd_chk("t1_rd_l1e17", 1, 17, 8'h5A);
      rd_chk("t1_rd_l0e17", 0, 17, 8'h00);

      // rejected writes
      wr(0, 12, 8'h77);
      check("t2_err_e12", 32'(wr_err), 32'd1);
      rd_chk("t2_rd_e12", 0, 12, 8'h00);
      wr(1, 25, 8'h66);
      check("t2_err_e25", 32'(wr_err), 32'd1);
      tick();
      check("t2_err_clear", 32'(wr_err), 32'd0);

      // full two-lane sequence, write and apply while busy
      fill();
      apply = 1'b1; apply_mask = 2'b11;
      tick();
      apply = 1'b0;
      for (int k = 1; k <= 43; k++) begin
         if (k == 4) begin wr_en = 1'b1; wr_addr = AW'(5); wr_data = 8'hEE; end
         if (k == 9) begin apply = 1'b1; apply_mask = 2'b01; end
         tick();
         wr_en = 1'b0; apply = 1'b0;
         check("t3_ld", 32'(ld_delay), (k <= 19) ? 32'd1 : (k <= 38) ? 32'd2 : 32'd0);
         check("t3_set", 32'(set), (k == 41) ? 32'd3 : 32'd0);
         check("t3_done", 32'(done), 32'(k == 42));
         check("t3_busy", 32'(busy), 32'(k <= 41));
         if (k == 4)  check("t3_busy_err", 32'(wr_err), 32'd1);
         if (k == 1)  check("t3_addr1", 32'(dly_addr), 32'd0);
         if (k == 1)  check("t3_data1", 32'(dly_data), 32'h3C);
         if (k == 10) check("t3_addr10", 32'(dly_addr), 32'd9);
         if (k == 11) check("t3_addr11", 32'(dly_addr), 32'd16);
         if (k == 20) check("t3_data20", 32'(dly_data), 32'h1C);
         if (k == 38) check("t3_addr38", 32'(dly_addr), 32'd24);
         if (k == 40) check("t3_hold40", 32'(dly_addr), 32'd24);
      end
      rd_chk("t3_rd_unchanged", 0, 5, 8'h39);

      // empty mask
      apply = 1'b1; apply_mask = 2'b00;
      tick();
      apply = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("t4_done", 32'(done), 32'(k == 1));
         check("t4_busy", 32'(busy), 32'd0);
         check("t4_ld",   32'(ld_delay), 32'd0);
         check("t4_set",  32'(set), 32'd0);
      end

      // reset in the middle of LOAD
      fill();
      apply = 1'b1; apply_mask = 2'b11;
      tick();
      apply = 1'b0;
      repeat (10) tick();
      check("t5_loading", 32'(ld_delay), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all_zero("t5_abort");
      repeat (3) tick();
      rst = 1'b0;
      for (int l = 0; l < NUM_LANES; l++)
         for (int e = 0; e < 32; e++)
            if (entry_ok(e)) rd_chk("t5_rd_zero", l, e, 8'h00);
      repeat (30) tick();

`ifdef PHY_DLY_SEQ_DIRTY_EN
      // dirty-only issue, then a sequence with nothing dirty
      wr(0, 3, 8'h11);
      wr(0, 20, 8'h22);
      apply = 1'b1; apply_mask = 2'b01;
      tick();
      apply = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("t6_ld",   32'(ld_delay), (k <= 2) ? 32'd1 : 32'd0);
         check("t6_set",  32'(set), (k == 5) ? 32'd1 : 32'd0);
         check("t6_done", 32'(done), 32'(k == 6));
         check("t6_busy", 32'(busy), 32'(k <= 5));
         if (k == 1) check("t6_addr1", 32'(dly_addr), 32'd3);
         if (k == 1) check("t6_data1", 32'(dly_data), 32'h11);
         if (k == 2) check("t6_addr2", 32'(dly_addr), 32'd20);
         if (k == 2) check("t6_data2", 32'(dly_data), 32'h22);
      end
      apply = 1'b1; apply_mask = 2'b01;
      tick();
      apply = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("t6b_ld",   32'(ld_delay), 32'd0);
         check("t6b_set",  32'(set), (k == 3) ? 32'd1 : 32'd0);
         check("t6b_done", 32'(done), 32'(k == 4));
      end
`endif

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         wr_en      = (($urandom % 3) == 0);
         wr_addr    = AW'($urandom);
         wr_data    = DLY_W'($urandom);
         rd_addr    = AW'($urandom);
         apply      = (($urandom % 25) == 0);
         apply_mask = NUM_LANES'($urandom);
         tick();
      end
      wr_en = 1'b0; apply = 1'b0;
      repeat (60) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
